// File: rtl/ysyx_23060061_mem_arbiter_if.sv
// Valid/ready memory bus: request channel (addr/wen/wdata/wstrb) plus response channel (rdata/err).
// "master" is the side that issues requests, "slave" the side that serves them.
interface ysyx_23060061_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     addr;
    logic                  wen;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     rdata;
    logic                  resp_err;

    modport master (
        output req_valid, addr, wen, wdata, wstrb, resp_ready,
        input  req_ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wstrb, resp_ready,
        output req_ready, resp_valid, rdata, resp_err
    );
endinterface

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (m0) and LSU (m1).
// One transaction in flight; grant is held from acceptance until the response handshake.
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_23060061_mem_arbiter_if.slave    m0,
    ysyx_23060061_mem_arbiter_if.slave    m1,
    ysyx_23060061_mem_arbiter_if.master   s
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_nxt;
    logic                  grant, last;
    logic                  win, accept, sel_resp_ready, resp_fire;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;

    // On a tie the master that was not served last wins; a lone requester always wins.
    assign win            = m1.req_valid & (~m0.req_valid | ~last);
    assign accept         = (state == IDLE) & (m0.req_valid | m1.req_valid);
    assign sel_resp_ready = grant ? m1.resp_ready : m0.resp_ready;
    assign resp_fire      = (state == RESP) & s.resp_valid & sel_resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        m0.req_ready  = 1'b0;
        m1.req_ready  = 1'b0;
        m0.resp_valid = 1'b0;
        m1.resp_valid = 1'b0;
        s.req_valid   = 1'b0;
        s.resp_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    m0.req_ready = ~win;
                    m1.req_ready = win;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                s.req_valid = 1'b1;
                if (s.req_ready) state_nxt = RESP;
            end
            RESP: begin
                s.resp_ready  = sel_resp_ready;
                m0.resp_valid = ~grant & s.resp_valid;
                m1.resp_valid = grant & s.resp_valid;
                if (resp_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fields are captured at acceptance so the slave sees them stable while the master moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant   <= 1'b0;
            last    <= 1'b1;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (accept) begin
                grant   <= win;
                addr_q  <= win ? m1.addr  : m0.addr;
                wen_q   <= win ? m1.wen   : m0.wen;
                wdata_q <= win ? m1.wdata : m0.wdata;
                wstrb_q <= win ? m1.wstrb : m0.wstrb;
            end
            if (resp_fire) last <= grant;
        end
    end

    assign s.addr      = addr_q;
    assign s.wen       = wen_q;
    assign s.wdata     = wdata_q;
    assign s.wstrb     = wstrb_q;

    assign m0.rdata    = s.rdata;
    assign m1.rdata    = s.rdata;
    assign m0.resp_err = s.resp_err;
    assign m1.resp_err = s.resp_err;
endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Bench for the two-master memory arbiter: directed scenarios then random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_ysyx_23060061_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    ysyx_23060061_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    ysyx_23060061_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if)
    );

    int checks = 0;
    int errors = 0;

    // master-side stimulus
    bit          pv[2];
    logic [31:0] pa[2];
    logic [31:0] pwd[2];
    bit          pwen[2];
    logic [3:0]  pws[2];
    bit          renew[2];
    bit          mrr[2];
    // slave-side stimulus
    bit          srdy, sresp_en, spur, serr;
    bit          sl_have;
    logic [31:0] sl_addr;
    // reference model: one outstanding transaction, round-robin by last served
    bit          busy, taken;
    int          cur_m, last_m;
    logic [31:0] cur_addr, cur_wdata;
    bit          cur_wen;
    logic [3:0]  cur_wstrb;
    int          obs_g[$];

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : ({a[15:0], a[31:16]} ^ 32'h5A5A_5A5A);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int m);
        pa[m]   = $urandom;
        pwd[m]  = $urandom;
        pwen[m] = 1'($urandom_range(0, 1));
        pws[m]  = 4'($urandom_range(0, 15));
    endtask

    task automatic drive();
        m0_if.req_valid  = pv[0];
        m0_if.addr       = pa[0];
        m0_if.wen        = pwen[0];
        m0_if.wdata      = pwd[0];
        m0_if.wstrb      = pws[0];
        m0_if.resp_ready = mrr[0];
        m1_if.req_valid  = pv[1];
        m1_if.addr       = pa[1];
        m1_if.wen        = pwen[1];
        m1_if.wdata      = pwd[1];
        m1_if.wstrb      = pws[1];
        m1_if.resp_ready = mrr[1];
        s_if.req_ready   = srdy;
        s_if.resp_valid  = sl_have ? sresp_en : spur;
        s_if.rdata       = sl_have ? sdata(sl_addr) : $urandom;
        s_if.resp_err    = serr;
    endtask

    task automatic model_reset();
        busy = 0; taken = 0; last_m = 1; cur_m = 0; sl_have = 0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cyc();
        int win;
        bit acc, rv, sresp, sfire, rfire, m_done, m_take;
        logic [31:0] s_addr_smp;
        drive();
        #2;
        acc = !busy && (pv[0] || pv[1]);
        if (pv[0] && pv[1]) win = 1 - last_m;
        else                win = pv[1] ? 1 : 0;
        chk("m0_req_ready", 64'(m0_if.req_ready), 64'(acc && win == 0));
        chk("m1_req_ready", 64'(m1_if.req_ready), 64'(acc && win == 1));
        chk("s_req_valid", 64'(s_if.req_valid), 64'(busy && !taken));
        if (busy && !taken) begin
            chk("s_addr", 64'(s_if.addr), 64'(cur_addr));
            chk("s_wen", 64'(s_if.wen), 64'(cur_wen));
            chk("s_wdata", 64'(s_if.wdata), 64'(cur_wdata));
            chk("s_wstrb", 64'(s_if.wstrb), 64'(cur_wstrb));
        end
        sresp = s_if.resp_valid;
        rv = busy && taken && sresp;
        chk("m0_resp_valid", 64'(m0_if.resp_valid), 64'(rv && cur_m == 0));
        chk("m1_resp_valid", 64'(m1_if.resp_valid), 64'(rv && cur_m == 1));
        chk("s_resp_ready", 64'(s_if.resp_ready), 64'(busy && taken && mrr[cur_m]));
        if (rv && mrr[cur_m]) begin
            chk("rdata", 64'(cur_m == 1 ? m1_if.rdata : m0_if.rdata), 64'(sdata(cur_addr)));
            chk("resp_err", 64'(cur_m == 1 ? m1_if.resp_err : m0_if.resp_err), 64'(serr));
        end
        if (m0_if.req_ready && pv[0]) obs_g.push_back(0);
        if (m1_if.req_ready && pv[1]) obs_g.push_back(1);
        sfire = s_if.req_valid && srdy;
        s_addr_smp = s_if.addr;
        rfire = sl_have && sresp_en && s_if.resp_ready;
        m_done = busy && taken && sresp && mrr[cur_m];
        m_take = busy && !taken && srdy;
        @(posedge clk);
        if (m_done) begin busy = 0; last_m = cur_m; end
        if (m_take) taken = 1;
        if (acc) begin
            busy = 1; taken = 0; cur_m = win;
            cur_addr = pa[win]; cur_wen = pwen[win]; cur_wdata = pwd[win]; cur_wstrb = pws[win];
            new_req(win);
            pv[win] = renew[win];
        end
        if (rfire) sl_have = 0;
        if (sfire) begin sl_have = 1; sl_addr = s_addr_smp; end
        #1;
    endtask

    initial begin
        int g0;
        for (int m = 0; m < 2; m++) begin
            pv[m] = 0; pa[m] = '0; pwd[m] = '0; pwen[m] = 0; pws[m] = '0; renew[m] = 0; mrr[m] = 1;
        end
        srdy = 0; sresp_en = 0; spur = 0; serr = 0; sl_addr = '0;
        model_reset();
        drive();
        #3;
        // reset state
        chk("rst_s_req_valid", 64'(s_if.req_valid), 64'd0);
        chk("rst_s_resp_ready", 64'(s_if.resp_ready), 64'd0);
        chk("rst_m0_resp_valid", 64'(m0_if.resp_valid), 64'd0);
        chk("rst_m1_resp_valid", 64'(m1_if.resp_valid), 64'd0);
        chk("rst_s_addr", 64'(s_if.addr), 64'd0);
        chk("rst_s_wdata", 64'(s_if.wdata), 64'd0);
        pv[0] = 1; drive(); #1;
        chk("rst_m0_req_ready_comb", 64'(m0_if.req_ready), 64'd1);
        pv[0] = 0; drive();
        @(posedge clk); #1;
        rst_n = 1;

        // m0 read, zero-wait slave
        pv[0] = 1; pa[0] = 32'h8000_0000; pwen[0] = 0; pwd[0] = '0; pws[0] = '0;
        srdy = 1; sresp_en = 1;
        repeat (4) cyc();

        // m1 write, slave holds off request for 3 cycles; m1 changes inputs after acceptance
        pv[1] = 1; pa[1] = 32'h8000_1000; pwen[1] = 1; pwd[1] = 32'h1234_5678; pws[1] = 4'hF;
        srdy = 0;
        repeat (4) cyc();
        srdy = 1;
        repeat (3) cyc();

        // granted m0 stalls its response for 5 cycles while m1 waits
        pv[0] = 1; pa[0] = 32'h8000_0040; pwen[0] = 0;
        pv[1] = 1; pa[1] = 32'h8000_2000; pwen[1] = 0;
        mrr[0] = 0;
        repeat (7) cyc();
        mrr[0] = 1;
        repeat (5) cyc();

        // slave error on m1, then m0 continues normally
        serr = 1; pv[1] = 1; pa[1] = 32'h8000_3000;
        repeat (4) cyc();
        serr = 0; pv[0] = 1; pa[0] = 32'h8000_0080;
        repeat (4) cyc();

        // asynchronous reset while m0's response is stalled in RESP
        pv[0] = 1; pa[0] = 32'h8000_00C0; mrr[0] = 0;
        repeat (3) cyc();
        chk("pre_rst_m0_resp_valid", 64'(m0_if.resp_valid), 64'd1);
        rst_n = 0;
        #2;
        chk("async_rst_m0_resp_valid", 64'(m0_if.resp_valid), 64'd0);
        chk("async_rst_s_resp_ready", 64'(s_if.resp_ready), 64'd0);
        chk("async_rst_s_req_valid", 64'(s_if.req_valid), 64'd0);
        chk("async_rst_s_addr", 64'(s_if.addr), 64'd0);
        pv[0] = 0; pv[1] = 0; mrr[0] = 1;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;

        // both masters requesting continuously: strict alternation starting with m0
        g0 = obs_g.size();
        pv[0] = 1; pv[1] = 1; renew[0] = 1; renew[1] = 1;
        new_req(0); new_req(1);
        repeat (12) cyc();
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_grant_%0d", i), 64'((g0 + i < obs_g.size()) ? obs_g[g0 + i] : -1), 64'(i % 2));

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pv[m] && $urandom_range(0, 3) == 0) begin pv[m] = 1; new_req(m); end
                else if (pv[m] && !busy && $urandom_range(0, 15) == 0) pv[m] = 0;
                renew[m] = 1'($urandom_range(0, 1));
                mrr[m] = ($urandom_range(0, 3) != 0);
            end
            srdy = ($urandom_range(0, 2) != 0);
            sresp_en = ($urandom_range(0, 2) != 0);
            spur = 1'($urandom_range(0, 1));
            serr = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
